// File: rtl/lfsr_random_bank_pkg.sv
// Shared types and constants for the LFSR random bank.
// Holds the draw FSM states, default LFSR constants and the draw mask helper.
package lfsr_random_bank_pkg;

    typedef enum logic [1:0] {
        DRAW_IDLE,
        DRAW_SAMPLE,
        DRAW_DONE
    } draw_state_e;

    localparam logic [15:0] DEFAULT_TAPS      = 16'h6B8E;
    localparam logic [15:0] DEFAULT_SEED_BASE = 16'hF073;

    // Smallest 2^k-1 covering limit-1; zero limit means the full range.
    function automatic logic [31:0] mask_from_limit(input logic [31:0] limit);
        logic [31:0] m;
        if (limit == 32'd0) begin
            return '1;
        end
        m = limit - 32'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/lfsr_random_bank_stage.sv
// One Galois LFSR channel: reset seed, seed load (wins over step) and step.
// Define RNG_ZERO_GUARD_EN to replace an all-zero load with the reset seed.
module lfsr_galois_stage
    import lfsr_random_bank_pkg::*;
#(
    parameter int             W          = 16,
    parameter logic [W-1:0]   TAPS       = W'(DEFAULT_TAPS),
    parameter logic [W-1:0]   RESET_SEED = W'(DEFAULT_SEED_BASE)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] state
);

    logic [W-1:0] stepped;
    logic [W-1:0] load_val;
    logic [W-1:0] fb_mask;

    // Stage 0 only ever receives the wrapped MSB, so tap bit 0 is ignored.
    assign fb_mask = {TAPS[W-1:1], 1'b0} & {W{state[W-1]}};
    assign stepped = {state[W-2:0], state[W-1]} ^ fb_mask;

`ifdef RNG_ZERO_GUARD_EN
    assign load_val = (load_data == '0) ? RESET_SEED : load_data;
`else
    assign load_val = load_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= stepped;
        end
    end

endmodule

// File: rtl/lfsr_random_bank.sv
// Bank of Galois LFSR channels with a bounded rejection-sampling draw on ch0.
// Optional RNG_ZERO_GUARD_EN makes zero seed loads fall back to the reset seed.
module lfsr_random_bank
    import lfsr_random_bank_pkg::*;
#(
    parameter int           W         = 16,
    parameter int           CHANNELS  = 2,
    parameter logic [W-1:0] TAPS      = W'(DEFAULT_TAPS),
    parameter logic [W-1:0] SEED_BASE = W'(DEFAULT_SEED_BASE),
    parameter int           MAX_TRIES = 8,
    localparam int          CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  STEP_EN,
    input  logic                  SEED_LOAD,
    input  logic [CH_W-1:0]       SEED_CH,
    input  logic [W-1:0]          SEED_DATA,
    output logic [W*CHANNELS-1:0] RANDOM_RESULT,
    input  logic                  DRAW_REQ,
    input  logic [W-1:0]          DRAW_LIMIT,
    output logic                  DRAW_VALID,
    output logic [W-1:0]          DRAW_VALUE,
    input  logic                  DRAW_ACK,
    output logic                  DRAW_RETRY_OUT
);

    draw_state_e  state_q, state_n;
    logic [W-1:0] limit_q, limit_n;
    logic [W-1:0] mask_q, mask_n;
    logic [3:0]   tries_q, tries_n;
    logic [W-1:0] value_q, value_n;
    logic         retry_q, retry_n;
    logic         valid_q, valid_n;

    logic [W-1:0] chan_state [CHANNELS];
    logic [W-1:0] cand;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        localparam logic [2*W-1:0] DBL = {SEED_BASE, SEED_BASE} << (i % W);
        localparam logic [W-1:0]   SEED = DBL[2*W-1:W];

        logic step;
        logic load;

        // ch0 keeps stepping while sampling so every try sees a fresh value.
        if (i == 0) begin : g_ch0
            assign step = STEP_EN || (state_q == DRAW_SAMPLE);
        end else begin : g_chn
            assign step = STEP_EN;
        end
        assign load = SEED_LOAD && (SEED_CH == CH_W'(i));

        lfsr_galois_stage #(
            .W          (W),
            .TAPS       (TAPS),
            .RESET_SEED (SEED)
        ) u_stage (
            .clk       (CLK),
            .rst       (RST),
            .step      (step),
            .load      (load),
            .load_data (SEED_DATA),
            .state     (chan_state[i])
        );

        assign RANDOM_RESULT[i*W +: W] = chan_state[i];
    end

    assign cand = chan_state[0] & mask_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= DRAW_IDLE;
            limit_q <= '0;
            mask_q  <= '0;
            tries_q <= '0;
            value_q <= '0;
            retry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            limit_q <= limit_n;
            mask_q  <= mask_n;
            tries_q <= tries_n;
            value_q <= value_n;
            retry_q <= retry_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state_q;
        limit_n = limit_q;
        mask_n  = mask_q;
        tries_n = tries_q;
        value_n = value_q;
        retry_n = retry_q;
        valid_n = valid_q;
        unique case (state_q)
            DRAW_IDLE: begin
                if (DRAW_REQ) begin
                    limit_n = DRAW_LIMIT;
                    mask_n  = W'(mask_from_limit(32'(DRAW_LIMIT)));
                    tries_n = '0;
                    retry_n = 1'b0;
                    state_n = DRAW_SAMPLE;
                end
            end
            DRAW_SAMPLE: begin
                if (limit_q == '0 || cand < limit_q) begin
                    value_n = cand;
                    valid_n = 1'b1;
                    state_n = DRAW_DONE;
                end else if (tries_q == 4'(MAX_TRIES - 1)) begin
                    // Out of tries: fold the rejected candidate into range.
                    value_n = cand - limit_q;
                    retry_n = 1'b1;
                    valid_n = 1'b1;
                    state_n = DRAW_DONE;
                end else begin
                    tries_n = tries_q + 4'd1;
                end
            end
            DRAW_DONE: begin
                if (DRAW_ACK) begin
                    valid_n = 1'b0;
                    state_n = DRAW_IDLE;
                end
            end
            default: begin
                state_n = DRAW_IDLE;
            end
        endcase
    end

    assign DRAW_VALID     = valid_q;
    assign DRAW_VALUE     = value_q;
    assign DRAW_RETRY_OUT = retry_q;

endmodule

// File: tb/tb_lfsr_random_bank.sv
// Directed bench for lfsr_random_bank with hand-computed expected values.
// Zero-load expectations follow whether RNG_ZERO_GUARD_EN is defined.
module tb_lfsr_random_bank;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        STEP_EN = 1'b0;
    logic        SEED_LOAD = 1'b0;
    logic [0:0]  SEED_CH = 1'b0;
    logic [15:0] SEED_DATA = '0;
    logic [31:0] RANDOM_RESULT;
    logic        DRAW_REQ = 1'b0;
    logic [15:0] DRAW_LIMIT = '0;
    logic        DRAW_VALID;
    logic [15:0] DRAW_VALUE;
    logic        DRAW_ACK = 1'b0;
    logic        DRAW_RETRY_OUT;

    int compared = 0;
    int mismatched = 0;
    int lat;

    lfsr_random_bank dut (
        .CLK            (CLK),
        .RST            (RST),
        .STEP_EN        (STEP_EN),
        .SEED_LOAD      (SEED_LOAD),
        .SEED_CH        (SEED_CH),
        .SEED_DATA      (SEED_DATA),
        .RANDOM_RESULT  (RANDOM_RESULT),
        .DRAW_REQ       (DRAW_REQ),
        .DRAW_LIMIT     (DRAW_LIMIT),
        .DRAW_VALID     (DRAW_VALID),
        .DRAW_VALUE     (DRAW_VALUE),
        .DRAW_ACK       (DRAW_ACK),
        .DRAW_RETRY_OUT (DRAW_RETRY_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic run_draw(input logic [15:0] lim, output int n);
        DRAW_REQ = 1'b1;
        DRAW_LIMIT = lim;
        n = 0;
        do begin
            tick();
            n++;
            DRAW_REQ = 1'b0;
        end while (!DRAW_VALID && n < 40);
    endtask

    task automatic ack();
        DRAW_ACK = 1'b1;
        tick();
        DRAW_ACK = 1'b0;
    endtask

    initial begin
        @(negedge CLK);
        do_reset();
        check("reset_result", RANDOM_RESULT, 32'hE0E7_F073);
        check("reset_valid", {31'd0, DRAW_VALID}, 32'd0);
        check("reset_value", {16'd0, DRAW_VALUE}, 32'd0);
        check("reset_retry", {31'd0, DRAW_RETRY_OUT}, 32'd0);

        STEP_EN = 1'b1;
        tick();
        STEP_EN = 1'b0;
        check("step1", RANDOM_RESULT, 32'hAA41_8B69);
        tick();
        check("hold", RANDOM_RESULT, 32'hAA41_8B69);

        STEP_EN = 1'b1;
        SEED_LOAD = 1'b1;
        SEED_CH = 1'b1;
        SEED_DATA = 16'h1234;
        tick();
        STEP_EN = 1'b0;
        SEED_LOAD = 1'b0;
        check("load_vs_step", RANDOM_RESULT, 32'h1234_7D5D);

        do_reset();
        run_draw(16'd0, lat);
        check("full_lat", lat, 2);
        check("full_value", {16'd0, DRAW_VALUE}, 32'h0000_F073);
        check("full_retry", {31'd0, DRAW_RETRY_OUT}, 32'd0);
        ack();
        check("full_ack", {31'd0, DRAW_VALID}, 32'd0);
        check("sample_steps", RANDOM_RESULT, 32'hE0E7_8B69);

        do_reset();
        run_draw(16'd9, lat);
        check("lim9_lat", lat, 2);
        check("lim9_value", {16'd0, DRAW_VALUE}, 32'd3);
        ack();

        do_reset();
        run_draw(16'd1, lat);
        check("lim1_lat", lat, 2);
        check("lim1_valid", {31'd0, DRAW_VALID}, 32'd1);
        check("lim1_value", {16'd0, DRAW_VALUE}, 32'd0);
        check("lim1_retry", {31'd0, DRAW_RETRY_OUT}, 32'd0);
        DRAW_REQ = 1'b1;
        DRAW_LIMIT = 16'd0;
        tick();
        tick();
        tick();
        DRAW_REQ = 1'b0;
        check("lim1_hold_valid", {31'd0, DRAW_VALID}, 32'd1);
        check("lim1_hold_value", {16'd0, DRAW_VALUE}, 32'd0);
        ack();
        check("lim1_ack", {31'd0, DRAW_VALID}, 32'd0);

        for (int k = 0; k < 1000; k++) begin
            run_draw(16'd9, lat);
            check("bulk_valid", {31'd0, DRAW_VALID}, 32'd1);
            check("bulk_range", {31'd0, DRAW_VALUE < 16'd9}, 32'd1);
            ack();
        end

        SEED_LOAD = 1'b1;
        SEED_CH = 1'b0;
        SEED_DATA = 16'h000F;
        run_draw(16'd9, lat);
        SEED_LOAD = 1'b0;
        check("forced_lat", lat, 9);
        check("forced_value", {16'd0, DRAW_VALUE}, 32'd6);
        check("forced_retry", {31'd0, DRAW_RETRY_OUT}, 32'd1);
        tick();
        tick();
        check("forced_hold_valid", {31'd0, DRAW_VALID}, 32'd1);
        check("forced_hold_value", {16'd0, DRAW_VALUE}, 32'd6);
        check("forced_hold_retry", {31'd0, DRAW_RETRY_OUT}, 32'd1);
        ack();

        SEED_LOAD = 1'b1;
        SEED_DATA = 16'h000F;
        DRAW_REQ = 1'b1;
        DRAW_LIMIT = 16'd9;
        tick();
        DRAW_REQ = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        check("rst_sample_valid", {31'd0, DRAW_VALID}, 32'd0);
        check("rst_sample_seeds", RANDOM_RESULT, 32'hE0E7_F073);
        RST = 1'b0;
        SEED_LOAD = 1'b0;
        tick();
        tick();
        tick();
        check("rst_no_valid", {31'd0, DRAW_VALID}, 32'd0);
        check("rst_idle_hold", RANDOM_RESULT, 32'hE0E7_F073);

        SEED_LOAD = 1'b1;
        SEED_CH = 1'b0;
        SEED_DATA = 16'h0000;
        tick();
        SEED_LOAD = 1'b0;
`ifdef RNG_ZERO_GUARD_EN
        check("zero_load", RANDOM_RESULT, 32'hE0E7_F073);
`else
        check("zero_load", RANDOM_RESULT, 32'hE0E7_0000);
`endif
        STEP_EN = 1'b1;
        tick();
        STEP_EN = 1'b0;
`ifdef RNG_ZERO_GUARD_EN
        check("zero_step", RANDOM_RESULT, 32'hAA41_8B69);
`else
        check("zero_step", RANDOM_RESULT, 32'hAA41_0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lfsr_random_bank.md
LFSR_RANDOM_BANK -- requirements
Module: lfsr_random_bank

Interface
REQ-001 SHALL have parameter W, default 16, LFSR width per channel (4..32).
REQ-002 SHALL have parameter CHANNELS, default 2, number of independent LFSR channels (1..8).
REQ-003 SHALL have parameter TAPS, default 16'h6B8E, Galois feedback mask (bit i XORed with MSB into stage i).
REQ-004 SHALL have parameter SEED_BASE, default 16'hF073, nonzero reset seed.
REQ-005 SHALL have parameter MAX_TRIES, default 8, rejection-sampling retry cap (1..15).
REQ-006 SHALL have port CLK, input, 1, sole clock; all logic on the rising edge.
REQ-007 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port STEP_EN, input, 1, advance all channels one step.
REQ-009 SHALL have port SEED_LOAD, input, 1, load SEED_DATA into channel SEED_CH.
REQ-010 SHALL have port SEED_CH, input, clog2(CHANNELS) (min 1), channel select for SEED_LOAD.
REQ-011 SHALL have port SEED_DATA, input, W, seed value.
REQ-012 SHALL have port RANDOM_RESULT, output, W*CHANNELS, {ch[CHANNELS-1],...,ch[0]} state concatenation.
REQ-013 SHALL have ports DRAW_REQ (input, 1), DRAW_LIMIT (input, W), DRAW_VALID (output, 1), DRAW_VALUE (output, W), DRAW_ACK (input, 1), DRAW_RETRY_OUT (output, 1): bounded-draw handshake.

Function
REQ-014 Each channel SHALL step as next[0]=s[W-1], next[i]=s[i-1]^(TAPS[i]&s[W-1]) for i>=1.
REQ-015 With STEP_EN=1, all channels SHALL step in the same cycle; with STEP_EN=0, channels other than ch0 SHALL hold.
REQ-016 When SEED_LOAD and a step coincide on the same channel, the load SHALL win; SEED_CH >= CHANNELS SHALL be ignored.
REQ-017 The draw FSM SHALL have states IDLE, SAMPLE, DONE.
REQ-018 IDLE: on DRAW_REQ=1, the FSM SHALL latch DRAW_LIMIT and mask M = (smallest 2^k)-1 >= LIMIT-1, clear the try counter, and go to SAMPLE; LIMIT=0 SHALL mean full range (M all ones, no rejection).
REQ-019 SAMPLE: candidate c = ch0 & M; if c < LIMIT (or LIMIT=0), the FSM SHALL set DRAW_VALUE=c and go to DONE; else it SHALL increment tries and stay in SAMPLE.
REQ-020 In SAMPLE, ch0 SHALL step every cycle regardless of STEP_EN, so each try sees a fresh value.
REQ-021 On the MAX_TRIES-th rejection, the FSM SHALL set DRAW_VALUE = c - LIMIT, assert DRAW_RETRY_OUT, and go to DONE.
REQ-022 DONE: DRAW_VALID=1 with DRAW_VALUE and DRAW_RETRY_OUT stable until DRAW_ACK=1; ACK SHALL return the FSM to IDLE in the next cycle; DRAW_REQ outside IDLE SHALL be ignored.
REQ-023 Minimum draw latency SHALL be 2 cycles (REQ at edge t, VALID high after edge t+2).
REQ-024 A SEED_LOAD to ch0 during SAMPLE SHALL take effect; the candidate for that cycle SHALL use the pre-load state.

Reset
REQ-025 RST SHALL set channel i to SEED_BASE rotated left by i, the FSM to IDLE, and DRAW_VALID, DRAW_VALUE and DRAW_RETRY_OUT to 0.
REQ-026 RST SHALL override SEED_LOAD, STEP_EN and a draw in progress; no DRAW_VALID SHALL follow reset.

Configuration
REQ-027 Macro RNG_ZERO_GUARD_EN defined: a SEED_LOAD of all-zero SHALL load that channel's reset seed instead.
REQ-028 Macro RNG_ZERO_GUARD_EN undefined: zero SHALL load as-is, and the channel SHALL then remain zero.

Structure
REQ-029 A shared package SHALL hold the draw-state enum, the default TAPS/SEED_BASE constants and a mask-from-limit function.
REQ-030 A single sub-module lfsr_galois_stage (one channel: step, load, state) SHALL be instantiated CHANNELS times.

Verification
REQ-031 Reset, defaults -> RANDOM_RESULT = 32'hE0E7_F073.
REQ-032 One cycle with STEP_EN=1 after reset -> ch0 = 16'h8B69, ch1 steps by the same rule.
REQ-033 SEED_LOAD ch1 = 16'h1234 with STEP_EN=1 in the same cycle -> ch1 = 16'h1234, ch0 steps.
REQ-034 DRAW_REQ with LIMIT=1 -> DRAW_VALID after 2 cycles, VALUE=0, RETRY_OUT=0; VALID holds until ACK.
REQ-035 LIMIT=9 (M=F), 1000 draws -> every VALUE < 9; a forced run of 8 rejections gives VALUE = c-9 with RETRY_OUT=1.
REQ-036 RST asserted in SAMPLE -> next cycle IDLE, DRAW_VALID=0, seeds restored; with RNG_ZERO_GUARD_EN defined, a zero load on ch0 gives ch0 = 16'hF073.
